// File: rtl/subtractor_8bit_serial.sv
// Bit-serial two's-complement subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// Optional signed-overflow output V is built only when OVERFLOW_FLAG_EN is defined.
module subtractor_8bit_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             V
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] r_sr;
    logic [WIDTH-1:0] r_cat;
    logic             bw;
    logic [CW-1:0]    cnt;
    logic             a_i;
    logic             b_i;
    logic             d;
    logic             bw_next;

    assign a_i     = a_sr[0];
    assign b_i     = b_sr[0];
    assign d       = a_i ^ b_i ^ bw;
    assign bw_next = (~a_i & b_i) | (~(a_i ^ b_i) & bw);
    // Incoming bit joins at the top; on the last step r_cat is the full difference.
    assign r_cat   = {d, r_sr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            bw    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            Diff  <= '0;
            Bout  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            V     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        bw    <= Bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_sr <= r_cat[WIDTH-1:1];
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    bw   <= bw_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        Diff  <= r_cat;
                        Bout  <= bw_next;
`ifdef OVERFLOW_FLAG_EN
                        // On the last step a_i/b_i are the operand MSBs and d is the result MSB.
                        V     <= (a_i != b_i) && (d != a_i);
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subtractor_8bit_serial.sv
// Self-checking bench for subtractor_8bit_serial: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_subtractor_8bit_serial;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             bin = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             v;

    int errors = 0;
    int checks = 0;

    subtractor_8bit_serial #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a),
        .B     (b),
        .Bin   (bin),
        .busy  (busy),
        .done  (done),
        .Diff  (diff),
        .Bout  (bout)
`ifdef OVERFLOW_FLAG_EN
        ,
        .V     (v)
`endif
    );

`ifndef OVERFLOW_FLAG_EN
    assign v = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted request yields its result WIDTH cycles later.
    logic             m_busy;
    logic             m_done;
    int               m_left;
    logic [WIDTH:0]   p_full;
    logic             p_v;
    logic [WIDTH-1:0] m_diff;
    logic             m_bout;
    logic             m_v;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
            p_full <= '0;
            p_v    <= 1'b0;
            m_diff <= '0;
            m_bout <= 1'b0;
            m_v    <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_diff <= p_full[WIDTH-1:0];
                    m_bout <= p_full[WIDTH];
                    m_v    <= p_v;
                end
            end else if (start) begin
                p_full <= {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
                p_v    <= (a[WIDTH-1] != b[WIDTH-1]) &&
                          (((a - b - {{(WIDTH-1){1'b0}}, bin}) >> (WIDTH-1)) != {{(WIDTH-1){1'b0}}, a[WIDTH-1]});
                m_busy <= 1'b1;
                m_left <= WIDTH;
            end
        end
    end

    always @(negedge clk) begin
        check("busy_vs_model", {31'b0, busy}, {31'b0, m_busy});
        check("done_vs_model", {31'b0, done}, {31'b0, m_done});
        check("diff_vs_model", {24'b0, diff}, {24'b0, m_diff});
        check("bout_vs_model", {31'b0, bout}, {31'b0, m_bout});
`ifdef OVERFLOW_FLAG_EN
        check("v_vs_model", {31'b0, v}, {31'b0, m_v});
`endif
    end

    task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bi);
        a     = av;
        b     = bv;
        bin   = bi;
        start = 1'b1;
    endtask

    // Called right after issue(); returns the number of falling edges until done.
    task automatic wait_done(output int n);
        @(negedge clk);
        start = 1'b0;
        a     = ~a;
        b     = ~b;
        bin   = ~bin;
        n     = 1;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_result(input string name, input int n, input logic [WIDTH-1:0] ed,
                                input logic eb, input logic ev);
        check({name, "_latency"}, n, 9);
        check({name, "_diff"}, {24'b0, diff}, {24'b0, ed});
        check({name, "_bout"}, {31'b0, bout}, {31'b0, eb});
`ifdef OVERFLOW_FLAG_EN
        check({name, "_v"}, {31'b0, v}, {31'b0, ev});
`else
        if (ev === 1'bx) $display("note: unexpected x in overflow expectation");
`endif
    endtask

    task automatic run_op(input string name, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic bi, input logic [WIDTH-1:0] ed, input logic eb, input logic ev);
        int n;
        @(negedge clk);
        issue(av, bv, bi);
        wait_done(n);
        check_result(name, n, ed, eb, ev);
    endtask

    logic [WIDTH-1:0] sweep_vals [11] = '{8'h00, 8'h01, 8'h02, 8'h3C, 8'h7E, 8'h7F,
                                           8'h80, 8'h81, 8'hC3, 8'hFE, 8'hFF};

    initial begin
        int n;
        int done_cnt;
        logic [WIDTH-1:0] seen_diff;
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] sd;

        #12;
        check("reset_busy", {31'b0, busy}, 0);
        check("reset_done", {31'b0, done}, 0);
        check("reset_diff", {24'b0, diff}, 0);
        check("reset_bout", {31'b0, bout}, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op("basic", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        run_op("wrap", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_op("wrap_bin", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op("ovf", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);

        // Back-to-back: start held in the DONE cycle.
        issue(8'h10, 8'h10, 1'b0);
        wait_done(n);
        check_result("b2b", n, 8'h00, 1'b0, 1'b0);

        // Start while busy must be ignored.
        @(negedge clk);
        issue(8'h20, 8'h05, 1'b0);
        done_cnt = 0;
        seen_diff = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = (i == 3);
            if (i == 3) begin
                a = 8'hAA;
                b = 8'h55;
            end
            if (done) begin
                done_cnt++;
                seen_diff = diff;
            end
        end
        check("busy_start_dones", done_cnt, 1);
        check("busy_start_diff", {24'b0, seen_diff}, 32'h1B);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        issue(8'h40, 8'h01, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", {31'b0, busy}, 0);
        check("midrst_diff", {24'b0, diff}, 0);
        check("midrst_bout", {31'b0, bout}, 0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("midrst_no_done", done_cnt, 0);
        run_op("after_rst", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

        // Corner-value grid, expectations from plain arithmetic.
        foreach (sweep_vals[i]) begin
            foreach (sweep_vals[j]) begin
                for (int k = 0; k < 2; k++) begin
                    full = {1'b0, sweep_vals[i]} - {1'b0, sweep_vals[j]} - 9'(k);
                    sd   = full[WIDTH-1:0];
                    run_op("grid", sweep_vals[i], sweep_vals[j], k[0], sd, full[WIDTH],
                           (sweep_vals[i][7] != sweep_vals[j][7]) && (sd[7] != sweep_vals[i][7]));
                end
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
